tri_pixel_sweeper: RTL and testbench
====================================

Name: tri_pixel_sweeper

Overview:
- Stage directly upstream of the per-pixel triangle test and depth compare.
- Accepts one screen-space triangle per valid/ready handshake and computes its screen-clipped bounding box.
- Sweeps that box one pixel per cycle and reads each pixel's stored {color, depth} word from the tile/frame BRAM.
- Presents coordinate, stored pixel word and triangle to the pixel test stage, aligned to BRAM read latency.

Parameters:
- SCREEN_W, 320, screen width in pixels; x range 0..SCREEN_W-1.
- SCREEN_H, 240, screen height in pixels; y range 0..SCREEN_H-1.
- RAM_LATENCY, 2, BRAM read latency in cycles from rd_en to rd_data.
- DRAIN_CYCLES, 2, extra idle cycles after the last read before the next triangle is accepted; covers the test stage plus write-back.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- tri_in  input  128  color|p1x|p1y|p2x|p2y|p3x|p3y|depth; 16-bit fields; coordinates signed, depth unsigned.
- tri_valid  input  1  tri_in valid.
- tri_ready  output  1  block can accept a triangle.
- rd_en  output  1  BRAM read strobe.
- rd_addr  output  17  BRAM address = y*SCREEN_W + x.
- rd_data  input  32  BRAM read data {color[15:0], depth[15:0]}; valid RAM_LATENCY cycles after rd_en.
- xcoord_out  output  9  pixel x to the test stage.
- ycoord_out  output  8  pixel y to the test stage.
- pixel_data_out  output  32  stored pixel word (rd_data forwarded).
- triangle_out  output  128  latched triangle.
- pixel_out_valid  output  1  outputs valid this cycle.
- busy  output  1  high in any state other than IDLE, or while the output pipe is non-empty.

Behaviour:
- Reset values (async on rst_n low): state IDLE; tri_ready=1; rd_en=0; rd_addr=0; pixel_out_valid=0; x/ycoord_out=0; triangle_out=0; busy=0; delay pipe cleared.
- Reset asserted mid-sweep aborts the current triangle immediately. No further rd_en or pixel_out_valid is produced after release until a new handshake.
- IDLE:
  - tri_ready=1.
  - On tri_valid&&tri_ready, latch tri_in and go to SETUP.
- SETUP (1 cycle):
  - Bounding box: xmin/xmax/ymin/ymax = signed min/max of the three vertex coordinates.
  - Clamp to [0, SCREEN_W-1] and [0, SCREEN_H-1].
  - Empty box goes back to IDLE with no reads. Empty means xmax<0, ymax<0, xmin>=SCREEN_W or ymin>=SCREEN_H.
  - Otherwise set x=xmin, y=ymin, addr=ymin*SCREEN_W+xmin, and go to SWEEP.
- SWEEP:
  - Each cycle: rd_en=1 and rd_addr=addr; push {x, y, valid} into a RAM_LATENCY-deep delay pipe.
  - Raster order, x fastest.
  - At x==xmax: x=xmin, y++, addr += SCREEN_W-(xmax-xmin). Otherwise x++, addr++.
  - After issuing (xmax, ymax), go to DRAIN.
- DRAIN:
  - Hold for RAM_LATENCY+DRAIN_CYCLES cycles, rd_en=0, then go to IDLE.
  - This guarantees each triangle's write-back lands before the next triangle reads an overlapping pixel.
- Output timing:
  - A read issued in cycle n appears in cycle n+RAM_LATENCY: x/ycoord_out registered from the pipe, pixel_out_valid=1, pixel_data_out=rd_data (combinational forward).
  - triangle_out holds the latched triangle and is stable through the whole sweep and drain.
- tri_ready is low in SETUP, SWEEP and DRAIN.
- A degenerate triangle (all vertices equal, on screen) sweeps exactly 1 pixel.
- Arithmetic: bbox math in signed 16-bit; addr in 17-bit unsigned; no wrap, since clamping bounds addr ≤ 76799.
- Throughput: 1 pixel/cycle in SWEEP. Overhead per triangle: 1 (accept) + 1 (SETUP) + RAM_LATENCY + DRAIN_CYCLES cycles.

Optional Feature:
- Macro: SWEEP_STATS_EN.
- Defined:
  - Adds output ports pixel_count[31:0] and tri_count[15:0].
  - pixel_count increments per issued rd_en; tri_count increments per accepted triangle, including dropped ones.
  - Both wrap at full scale and reset to 0 on rst_n low.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Tri (10,10),(14,10),(10,13), RAM_LATENCY=2: 20 rd_en pulses; first rd_addr 3210, last 4174; pixel_out_valid 20 consecutive cycles starting 2 after first rd_en; coords (10,10)..(14,13) in raster order.
- Tri (-5,-5),(3,-5),(-5,2): clipped box x0..3, y0..2; 12 reads; addrs 0..3, 320..323, 640..643.
- Tri (400,10),(410,10),(400,20): no rd_en, no pixel_out_valid; tri_ready high again 2 cycles after the handshake.
- Two back-to-back identical 1-pixel tris at (5,5), tri_valid held high: second rd_en occurs ≥ 1+RAM_LATENCY+DRAIN_CYCLES+2 cycles after the first.
- Assert rst_n low mid-sweep of the first test: all outputs at reset values within the same cycle; no stray pixel_out_valid after release.
- With SWEEP_STATS_EN: run the first and third tests -> pixel_count=20, tri_count=2.

Source files
------------

// File: rtl/tri_pixel_sweeper.sv
`default_nettype none
//==============================================================================
// Module : tri_pixel_sweeper
// Brief  : Clips a triangle's bounding box to the screen and sweeps it one
//          pixel per cycle, reading the stored pixel word and presenting it
//          latency-aligned. Optional counters: define SWEEP_STATS_EN.
// Rev    : 1.0
//==============================================================================
module tri_pixel_sweeper #(
    parameter int SCREEN_W     = 320,
    parameter int SCREEN_H     = 240,
    parameter int RAM_LATENCY  = 2,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] tri_in,
    input  logic         tri_valid,
    output logic         tri_ready,
    output logic         rd_en,
    output logic [16:0]  rd_addr,
    input  logic [31:0]  rd_data,
    output logic [8:0]   xcoord_out,
    output logic [7:0]   ycoord_out,
    output logic [31:0]  pixel_data_out,
    output logic [127:0] triangle_out,
    output logic         pixel_out_valid,
`ifdef SWEEP_STATS_EN
    output logic [31:0]  pixel_count,
    output logic [15:0]  tri_count,
    output logic         busy
`else
    output logic         busy
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SWEEP = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic signed [15:0] c_x_last     = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] c_y_last     = 16'(SCREEN_H - 1);
    localparam logic [7:0]         c_drain_last = 8'(RAM_LATENCY + DRAIN_CYCLES - 1);

    state_t       r_state;
    logic [127:0] r_tri;
    logic         r_tri_ready;
    logic         r_rd_en;
    logic [16:0]  r_addr;
    logic [8:0]   r_x, r_xmin, r_xmax;
    logic [7:0]   r_y, r_ymin, r_ymax;
    logic [7:0]   r_drain;
    logic         r_pv [RAM_LATENCY];
    logic [8:0]   r_px [RAM_LATENCY];
    logic [7:0]   r_py [RAM_LATENCY];

    function automatic logic signed [15:0] smin3(input logic signed [15:0] a,
                                                 input logic signed [15:0] b,
                                                 input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    function automatic logic signed [15:0] smax3(input logic signed [15:0] a,
                                                 input logic signed [15:0] b,
                                                 input logic signed [15:0] c);
        logic signed [15:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    logic signed [15:0] w_bx_lo, w_bx_hi, w_by_lo, w_by_hi;
    logic signed [15:0] w_cx_lo, w_cx_hi, w_cy_lo, w_cy_hi;
    logic               w_empty, w_accept, w_pipe_busy, w_unused;
    logic [16:0]        w_start_addr;

    assign w_bx_lo = smin3(r_tri[111:96], r_tri[79:64], r_tri[47:32]);
    assign w_bx_hi = smax3(r_tri[111:96], r_tri[79:64], r_tri[47:32]);
    assign w_by_lo = smin3(r_tri[95:80],  r_tri[63:48], r_tri[31:16]);
    assign w_by_hi = smax3(r_tri[95:80],  r_tri[63:48], r_tri[31:16]);

    assign w_empty = (w_bx_hi < 16'sd0) || (w_by_hi < 16'sd0) ||
                     (w_bx_lo > c_x_last) || (w_by_lo > c_y_last);

    // A non-empty box can only overhang low on its min side and high on its max side.
    assign w_cx_lo = (w_bx_lo < 16'sd0)   ? 16'sd0   : w_bx_lo;
    assign w_cx_hi = (w_bx_hi > c_x_last) ? c_x_last : w_bx_hi;
    assign w_cy_lo = (w_by_lo < 16'sd0)   ? 16'sd0   : w_by_lo;
    assign w_cy_hi = (w_by_hi > c_y_last) ? c_y_last : w_by_hi;

    assign w_start_addr = 17'(w_cy_lo[7:0]) * 17'(SCREEN_W) + 17'(w_cx_lo[8:0]);
    assign w_unused     = ^{w_cx_lo[15:9], w_cx_hi[15:9], w_cy_lo[15:8], w_cy_hi[15:8]};
    assign w_accept     = (r_state == S_IDLE) && tri_valid && r_tri_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_tri       <= '0;
            r_tri_ready <= 1'b1;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_x         <= '0;
            r_xmin      <= '0;
            r_xmax      <= '0;
            r_y         <= '0;
            r_ymin      <= '0;
            r_ymax      <= '0;
            r_drain     <= '0;
            for (int i = 0; i < RAM_LATENCY; i++) begin
                r_pv[i] <= 1'b0;
                r_px[i] <= '0;
                r_py[i] <= '0;
            end
        end else begin
            // Delay pipe tracks each issued read until its data returns.
            r_pv[0] <= r_rd_en;
            r_px[0] <= r_x;
            r_py[0] <= r_y;
            for (int i = RAM_LATENCY - 1; i > 0; i--) begin
                r_pv[i] <= r_pv[i-1];
                r_px[i] <= r_px[i-1];
                r_py[i] <= r_py[i-1];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_tri       <= tri_in;
                        r_tri_ready <= 1'b0;
                        r_state     <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (w_empty) begin
                        r_tri_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_xmin  <= w_cx_lo[8:0];
                        r_xmax  <= w_cx_hi[8:0];
                        r_ymin  <= w_cy_lo[7:0];
                        r_ymax  <= w_cy_hi[7:0];
                        r_x     <= w_cx_lo[8:0];
                        r_y     <= w_cy_lo[7:0];
                        r_addr  <= w_start_addr;
                        r_rd_en <= 1'b1;
                        r_state <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    if (r_x == r_xmax) begin
                        if (r_y == r_ymax) begin
                            r_rd_en <= 1'b0;
                            r_drain <= c_drain_last;
                            r_state <= S_DRAIN;
                        end else begin
                            r_x    <= r_xmin;
                            r_y    <= r_y + 8'd1;
                            r_addr <= r_addr + 17'(SCREEN_W) - 17'(r_xmax) + 17'(r_xmin);
                        end
                    end else begin
                        r_x    <= r_x + 9'd1;
                        r_addr <= r_addr + 17'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain == 8'd0) begin
                        r_tri_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_drain <= r_drain - 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_pipe_busy = 1'b0;
        for (int i = 0; i < RAM_LATENCY; i++) begin
            w_pipe_busy = w_pipe_busy | r_pv[i];
        end
    end

    assign tri_ready       = r_tri_ready;
    assign rd_en           = r_rd_en;
    assign rd_addr         = r_addr;
    assign xcoord_out      = r_px[RAM_LATENCY-1];
    assign ycoord_out      = r_py[RAM_LATENCY-1];
    assign pixel_out_valid = r_pv[RAM_LATENCY-1];
    assign pixel_data_out  = rd_data;
    assign triangle_out    = r_tri;
    assign busy            = (r_state != S_IDLE) || w_pipe_busy;

`ifdef SWEEP_STATS_EN
    logic [31:0] r_pixel_count;
    logic [15:0] r_tri_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pixel_count <= '0;
            r_tri_count   <= '0;
        end else begin
            if (r_rd_en) r_pixel_count <= r_pixel_count + 32'd1;
            if (w_accept) r_tri_count <= r_tri_count + 16'd1;
        end
    end

    assign pixel_count = r_pixel_count;
    assign tri_count   = r_tri_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tri_pixel_sweeper.sv
`default_nettype none
//==============================================================================
// Module : tb_tri_pixel_sweeper
// Brief  : Self-checking bench: directed cases plus random triangles against
//          a bounding-box raster model.
// Rev    : 1.0
//==============================================================================
module tb_tri_pixel_sweeper;

    localparam int W = 320;
    localparam int H = 240;
    localparam int L = 2;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] tri_in;
    logic         tri_valid;
    logic         tri_ready;
    logic         rd_en;
    logic [16:0]  rd_addr;
    logic [31:0]  rd_data;
    logic [8:0]   xcoord_out;
    logic [7:0]   ycoord_out;
    logic [31:0]  pixel_data_out;
    logic [127:0] triangle_out;
    logic         pixel_out_valid;
    logic         busy;
`ifdef SWEEP_STATS_EN
    logic [31:0]  pixel_count;
    logic [15:0]  tri_count;
`endif

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          rd_cyc[$];
    int          rd_adr[$];
    int          out_cyc[$];
    int          out_x[$];
    int          out_y[$];
    logic [31:0] out_d[$];
    int          tri_bad;

    tri_pixel_sweeper #(
        .SCREEN_W(W), .SCREEN_H(H), .RAM_LATENCY(L), .DRAIN_CYCLES(D)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tri_in(tri_in),
        .tri_valid(tri_valid),
        .tri_ready(tri_ready),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .xcoord_out(xcoord_out),
        .ycoord_out(ycoord_out),
        .pixel_data_out(pixel_data_out),
        .triangle_out(triangle_out),
        .pixel_out_valid(pixel_out_valid),
`ifdef SWEEP_STATS_EN
        .pixel_count(pixel_count),
        .tri_count(tri_count),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM stand-in: every address holds a word derived from the address.
    function automatic logic [31:0] word_of(input logic [16:0] a);
        return {15'h5A5A, a};
    endfunction

    logic [16:0] m_pipe [L];
    always @(posedge clk) begin
        m_pipe[0] <= rd_addr;
        for (int i = 1; i < L; i++) m_pipe[i] <= m_pipe[i-1];
    end
    assign rd_data = word_of(m_pipe[L-1]);

    function automatic logic [127:0] pack_tri(input int x1, input int y1, input int x2,
                                              input int y2, input int x3, input int y3,
                                              input logic [15:0] color,
                                              input logic [15:0] depth);
        return {color, 16'(x1), 16'(y1), 16'(x2), 16'(y2), 16'(x3), 16'(y3), depth};
    endfunction

    // Hands one triangle over and records all DUT activity until it is idle again.
    task automatic run_tri(input logic [127:0] t, output int acc, output int rdy);
        int w;
        rd_cyc.delete(); rd_adr.delete(); out_cyc.delete();
        out_x.delete(); out_y.delete(); out_d.delete();
        tri_bad = 0;
        w = 0;
        @(negedge clk);
        while (!tri_ready && w < 500) begin @(negedge clk); w++; end
        tri_in = t; tri_valid = 1'b1; acc = cyc;
        rdy = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            tri_valid = 1'b0;
            if (rd_en) begin rd_cyc.push_back(cyc); rd_adr.push_back(int'(rd_addr)); end
            if (pixel_out_valid) begin
                out_cyc.push_back(cyc); out_x.push_back(int'(xcoord_out));
                out_y.push_back(int'(ycoord_out)); out_d.push_back(pixel_data_out);
                if (triangle_out !== t) tri_bad++;
            end
            if (tri_ready && !busy) begin rdy = cyc; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; tri_valid = 1'b0; tri_in = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (tri_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_ready_busy: got ready=%0b busy=%0b want 1 0", tri_ready, busy);
        end
        checks++;
        if (rd_en !== 1'b0 || rd_addr !== 17'd0 || pixel_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rd: got rd_en=%0b addr=%0d pov=%0b want 0 0 0", rd_en, rd_addr, pixel_out_valid);
        end
        checks++;
        if (xcoord_out !== 9'd0 || ycoord_out !== 8'd0 || triangle_out !== 128'd0) begin
            errors++; $display("FAIL reset_outs: got x=%0d y=%0d tri=%h want zeros", xcoord_out, ycoord_out, triangle_out);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int acc, rdy, first, last, bad;
        run_tri(pack_tri(10, 10, 14, 10, 10, 13, 16'hF00D, 16'h1234), acc, rdy);
        first = (rd_adr.size() > 0) ? rd_adr[0] : -1;
        last  = (rd_adr.size() > 0) ? rd_adr[rd_adr.size()-1] : -1;
        checks++;
        if (rd_adr.size() != 20) begin errors++; $display("FAIL basic_reads: got %0d want 20", rd_adr.size()); end
        checks++;
        if (first != 3210) begin errors++; $display("FAIL basic_first_addr: got %0d want 3210", first); end
        checks++;
        if (last != 4174) begin errors++; $display("FAIL basic_last_addr: got %0d want 4174", last); end
        checks++;
        if (out_cyc.size() != 20) begin errors++; $display("FAIL basic_outs: got %0d want 20", out_cyc.size()); end
        bad = 0;
        for (int i = 0; i < out_cyc.size(); i++) begin
            if (out_cyc[i] != acc + 2 + L + i || out_x[i] != 10 + i % 5 || out_y[i] != 10 + i / 5 ||
                out_d[i] !== word_of(17'((10 + i / 5) * W + 10 + i % 5))) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_raster: got %0d bad outputs want 0", bad); end
        checks++;
        if (tri_bad != 0) begin errors++; $display("FAIL basic_triangle_out: got %0d bad want 0", tri_bad); end
        checks++;
        if (rdy != acc + 2 + 20 + L + D) begin errors++; $display("FAIL basic_ready: got %0d want %0d", rdy - acc, 2 + 20 + L + D); end
    endtask

    task automatic test_clip();
        int acc, rdy, bad;
        int exp_a[12] = '{0, 1, 2, 3, 320, 321, 322, 323, 640, 641, 642, 643};
        run_tri(pack_tri(-5, -5, 3, -5, -5, 2, 16'h00FF, 16'h8000), acc, rdy);
        checks++;
        if (rd_adr.size() != 12) begin errors++; $display("FAIL clip_reads: got %0d want 12", rd_adr.size()); end
        bad = 0;
        for (int i = 0; i < rd_adr.size() && i < 12; i++) if (rd_adr[i] != exp_a[i]) bad++;
        for (int i = 0; i < out_x.size(); i++) if (out_x[i] != i % 4 || out_y[i] != i / 4) bad++;
        checks++;
        if (bad != 0 || out_x.size() != 12) begin
            errors++; $display("FAIL clip_addr_coords: got %0d bad, %0d outs want 0 bad, 12 outs", bad, out_x.size());
        end
        checks++;
        if (rdy != acc + 2 + 12 + L + D) begin errors++; $display("FAIL clip_ready: got %0d want %0d", rdy - acc, 2 + 12 + L + D); end
    endtask

    task automatic test_empty();
        int acc, rdy;
        run_tri(pack_tri(400, 10, 410, 10, 400, 20, 16'h1111, 16'h2222), acc, rdy);
        checks++;
        if (rd_adr.size() != 0 || out_cyc.size() != 0) begin
            errors++; $display("FAIL empty_activity: got reads=%0d outs=%0d want 0 0", rd_adr.size(), out_cyc.size());
        end
        checks++;
        if (rdy != acc + 2) begin errors++; $display("FAIL empty_ready: got %0d want 2", rdy - acc); end
    endtask

    task automatic test_random();
        int xs[3], ys[3];
        int ex[$], ey[$], ea[$];
        int acc, rdy, cx, cy, bx0, bx1, by0, by1, bad, want_rdy;
        for (int n = 0; n < 25; n++) begin
            cx = int'($urandom_range(0, 420)) - 50;
            cy = int'($urandom_range(0, 340)) - 50;
            for (int j = 0; j < 3; j++) begin
                xs[j] = (n % 7 == 0) ? cx : cx + int'($urandom_range(0, 16)) - 8;
                ys[j] = (n % 7 == 0) ? cy : cy + int'($urandom_range(0, 16)) - 8;
            end
            bx0 = xs[0]; bx1 = xs[0]; by0 = ys[0]; by1 = ys[0];
            for (int j = 1; j < 3; j++) begin
                if (xs[j] < bx0) bx0 = xs[j];
                if (xs[j] > bx1) bx1 = xs[j];
                if (ys[j] < by0) by0 = ys[j];
                if (ys[j] > by1) by1 = ys[j];
            end
            ex.delete(); ey.delete(); ea.delete();
            if (!(bx1 < 0 || by1 < 0 || bx0 >= W || by0 >= H)) begin
                if (bx0 < 0) bx0 = 0;
                if (by0 < 0) by0 = 0;
                if (bx1 > W - 1) bx1 = W - 1;
                if (by1 > H - 1) by1 = H - 1;
                for (int y = by0; y <= by1; y++)
                    for (int x = bx0; x <= bx1; x++) begin
                        ex.push_back(x); ey.push_back(y); ea.push_back(y * W + x);
                    end
            end
            run_tri(pack_tri(xs[0], ys[0], xs[1], ys[1], xs[2], ys[2],
                             16'($urandom), 16'($urandom)), acc, rdy);
            checks++;
            if (rd_adr.size() != ea.size()) begin
                errors++; $display("FAIL rand%0d_reads: got %0d want %0d", n, rd_adr.size(), ea.size());
            end
            bad = 0;
            for (int i = 0; i < rd_adr.size() && i < ea.size(); i++)
                if (rd_adr[i] != ea[i] || rd_cyc[i] != acc + 2 + i) bad++;
            checks++;
            if (bad != 0) begin errors++; $display("FAIL rand%0d_read_seq: got %0d bad want 0", n, bad); end
            bad = 0;
            for (int i = 0; i < out_cyc.size() && i < ea.size(); i++)
                if (out_cyc[i] != acc + 2 + L + i || out_x[i] != ex[i] || out_y[i] != ey[i] ||
                    out_d[i] !== word_of(17'(ea[i]))) bad++;
            checks++;
            if (bad != 0 || out_cyc.size() != ea.size() || tri_bad != 0) begin
                errors++; $display("FAIL rand%0d_outputs: got %0d bad, %0d outs, %0d tri_bad want 0, %0d, 0",
                                   n, bad, out_cyc.size(), tri_bad, ea.size());
            end
            want_rdy = (ea.size() == 0) ? acc + 2 : acc + 2 + ea.size() + L + D;
            checks++;
            if (rdy != want_rdy) begin errors++; $display("FAIL rand%0d_ready: got %0d want %0d", n, rdy - acc, want_rdy - acc); end
        end
    endtask

    task automatic test_back_to_back();
        int c1, c2, a1, a2, w;
        c1 = -1; c2 = -1; a1 = -1; a2 = -1; w = 0;
        @(negedge clk);
        while (!tri_ready && w < 500) begin @(negedge clk); w++; end
        tri_in = pack_tri(5, 5, 5, 5, 5, 5, 16'hABCD, 16'h0042);
        tri_valid = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (rd_en) begin
                if (c1 < 0) begin c1 = cyc; a1 = int'(rd_addr); end
                else begin c2 = cyc; a2 = int'(rd_addr); tri_valid = 1'b0; break; end
            end
        end
        tri_valid = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (tri_ready && !busy) break;
        end
        checks++;
        if (c1 < 0 || c2 < 0 || c2 - c1 < 1 + L + D + 2) begin
            errors++; $display("FAIL b2b_spacing: got first=%0d second=%0d want gap >= %0d", c1, c2, 1 + L + D + 2);
        end
        checks++;
        if (a1 != 1605 || a2 != 1605) begin errors++; $display("FAIL b2b_addr: got %0d %0d want 1605 1605", a1, a2); end
    endtask

    task automatic test_reset_mid_sweep();
        int seen, stray, w;
        seen = 0; stray = 0; w = 0;
        @(negedge clk);
        while (!tri_ready && w < 500) begin @(negedge clk); w++; end
        tri_in = pack_tri(10, 10, 14, 10, 10, 13, 16'hF00D, 16'h1234);
        tri_valid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            tri_valid = 1'b0;
            if (rd_en) seen++;
            if (seen == 5) break;
        end
        checks++;
        if (seen != 5) begin errors++; $display("FAIL midrst_sweep_started: got %0d reads want 5", seen); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_en !== 1'b0 || pixel_out_valid !== 1'b0 || rd_addr !== 17'd0) begin
            errors++; $display("FAIL midrst_rd: got rd_en=%0b pov=%0b addr=%0d want 0 0 0", rd_en, pixel_out_valid, rd_addr);
        end
        checks++;
        if (tri_ready !== 1'b1 || busy !== 1'b0 || triangle_out !== 128'd0 ||
            xcoord_out !== 9'd0 || ycoord_out !== 8'd0) begin
            errors++; $display("FAIL midrst_outs: got ready=%0b busy=%0b x=%0d y=%0d tri=%h want 1 0 0 0 0",
                               tri_ready, busy, xcoord_out, ycoord_out, triangle_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (rd_en || pixel_out_valid) stray++;
        end
        checks++;
        if (stray != 0 || tri_ready !== 1'b1) begin
            errors++; $display("FAIL midrst_release: got %0d stray cycles ready=%0b want 0 1", stray, tri_ready);
        end
    endtask

`ifdef SWEEP_STATS_EN
    task automatic test_stats();
        checks++;
        if (pixel_count !== 32'd20) begin errors++; $display("FAIL stats_pixels: got %0d want 20", pixel_count); end
        checks++;
        if (tri_count !== 16'd2) begin errors++; $display("FAIL stats_tris: got %0d want 2", tri_count); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_empty();
`ifdef SWEEP_STATS_EN
        test_stats();
`endif
        test_clip();
        test_random();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
